hash_table_reader: RTL and testbench
====================================

Name: hash_table_reader

Overview:
- Drains the hash/occurrence table after the hash builder finishes a pass.
- Scans every slot of the table in address order and skips empty slots (occurrence 0).
- Streams the remaining (hash value, occurrence count, slot) triples over a valid/ready interface to the frequency-export logic.
- Shares the table's port signals (HashOccurrAddr/HashValue/OccurrValue/WrEn/NewHashValue/NewOccurrValue) with the builder, arbitrated outside this block.

Parameters:
- DATA_INDEX_WIDTH, 32, width of hash value and occurrence count.
- BIT_ON_TAILS, 7, table holds 1<<BIT_ON_TAILS slots; address width BIT_ON_TAILS+1.
- MIN_OCCURR, 1, slots with OccurrValue < MIN_OCCURR are skipped; a value of 0 is treated as 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a scan; ignored unless Idle.
- abort  in  1  level; forces return to Idle.
- busy  out  1  high in every state except Idle.
- done  out  1  one-cycle pulse when the scan completes.
- HashOccurrAddr  out  BIT_ON_TAILS+1  table read/write address.
- HashValue  in  DATA_INDEX_WIDTH  table hash data, valid one cycle after the address.
- OccurrValue  in  DATA_INDEX_WIDTH  table occurrence data, same timing as HashValue.
- WrEn  out  1  table write strobe (optional feature only).
- NewHashValue  out  DATA_INDEX_WIDTH  write data, always 0.
- NewOccurrValue  out  DATA_INDEX_WIDTH  write data, always 0.
- out_valid  out  1  output triple valid.
- out_ready  in  1  consumer accepts.
- out_value  out  DATA_INDEX_WIDTH  hash value.
- out_count  out  DATA_INDEX_WIDTH  occurrence count.
- out_slot  out  BIT_ON_TAILS+1  slot address of the triple.
- entry_count  out  BIT_ON_TAILS+1  number of triples accepted this scan.
- total_occurr  out  DATA_INDEX_WIDTH  sum of accepted counts, modulo 2^DATA_INDEX_WIDTH.

Behaviour:
- Reset (rst low, asynchronous): state Idle; all outputs 0, including addr, counters and out_* registers.
- States: Idle, ReadWait, Sample, Emit, Advance, Done.
- Idle:
  - On start: addr←0, entry_count←0, total_occurr←0, go to ReadWait.
  - entry_count and total_occurr hold their values from the previous scan until the next start.
- ReadWait: address stable one cycle (synchronous table read), then go to Sample.
- Sample:
  - Register HashValue/OccurrValue into out_value/out_count and addr into out_slot.
  - If OccurrValue ≥ max(MIN_OCCURR,1), go to Emit; else go to Advance.
- Emit:
  - out_valid=1; out_value/out_count/out_slot held stable.
  - On out_valid&&out_ready: entry_count+1, total_occurr+out_count, go to Advance.
  - out_valid only drops after acceptance or abort.
- Advance:
  - If addr == (1<<BIT_ON_TAILS)-1, go to Done.
  - Else addr+1, go to ReadWait.
- Done: done=1 for exactly one cycle, addr←0, go to Idle.
- Timing:
  - An empty slot costs 3 cycles.
  - A full slot costs 4 cycles plus the consumer stall.
  - A full scan of an empty table is 3·2^BIT_ON_TAILS+1 cycles from start to the done pulse.
- abort: takes priority in any state.
  - Next state is Idle; out_valid and WrEn are 0 the next cycle; done is not pulsed.
  - Counters keep their partial values.
- start while busy: ignored. start and abort in the same cycle while Idle: abort wins and the block stays Idle.
- The address never exceeds (1<<BIT_ON_TAILS)-1; the top address bit is always 0.
- out_valid is never asserted outside Emit.

Optional Feature:
- Macro: CLEAR_ON_READ_EN.
- Defined:
  - In Advance, if the slot was emitted and accepted, WrEn=1 for one cycle at the current addr with NewHashValue=0 and NewOccurrValue=0.
  - After a full scan, the table is empty and ready for the next build pass.
  - Skipped slots are never written.
- Undefined: WrEn is tied 0 and the table is unchanged.

Test Plan:
- Empty table, BIT_ON_TAILS=3, start pulse → out_valid never asserted, done pulses exactly 25 cycles after start, entry_count=0.
- Slots 2 (value 0xAB, count 5) and 7 (value 0x10, count 1), out_ready=1 → two triples in order (0xAB,5,2) then (0x10,1,7), entry_count=2, total_occurr=6.
- Same table, out_ready held low 10 cycles on the first triple → out_valid stays high with stable data, no address change, then continues normally.
- MIN_OCCURR=3, counts {slot1:2, slot4:3} → only slot 4 emitted.
- abort asserted during Emit of slot 2 → next cycle out_valid=0, busy=0, no done pulse; a new start rescans from slot 0.
- With CLEAR_ON_READ_EN defined, the table from scenario 2 → WrEn pulses at addr 2 and addr 7 only, with zero data; a rescan emits nothing.

Source files
------------

// File: rtl/hash_table_reader.sv
// Drains the hash/occurrence table in address order, streaming non-empty slots as
// (value, count, slot) triples. Define CLEAR_ON_READ_EN to zero accepted slots during the scan.
module hash_table_reader #(
    parameter int DATA_INDEX_WIDTH = 32,
    parameter int BIT_ON_TAILS     = 7,
    parameter int MIN_OCCURR       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [BIT_ON_TAILS:0]       HashOccurrAddr,
    input  logic [DATA_INDEX_WIDTH-1:0] HashValue,
    input  logic [DATA_INDEX_WIDTH-1:0] OccurrValue,
    output logic                        WrEn,
    output logic [DATA_INDEX_WIDTH-1:0] NewHashValue,
    output logic [DATA_INDEX_WIDTH-1:0] NewOccurrValue,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_INDEX_WIDTH-1:0] out_value,
    output logic [DATA_INDEX_WIDTH-1:0] out_count,
    output logic [BIT_ON_TAILS:0]       out_slot,
    output logic [BIT_ON_TAILS:0]       entry_count,
    output logic [DATA_INDEX_WIDTH-1:0] total_occurr
);
    localparam int AW  = BIT_ON_TAILS + 1;
    localparam int THR = (MIN_OCCURR < 1) ? 1 : MIN_OCCURR;
    localparam logic [AW-1:0]               LAST_ADDR = AW'((1 << BIT_ON_TAILS) - 1);
    localparam logic [DATA_INDEX_WIDTH-1:0] THR_V     = DATA_INDEX_WIDTH'(THR);

    typedef enum logic [2:0] {IDLE, READ_WAIT, SAMPLE, EMIT, ADVANCE, DONE} state_t;

    state_t        state, state_n;
    logic [AW-1:0] addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:      if (start) state_n = READ_WAIT;
                READ_WAIT: state_n = SAMPLE;
                SAMPLE:    state_n = (OccurrValue >= THR_V) ? EMIT : ADVANCE;
                EMIT:      if (out_ready) state_n = ADVANCE;
                ADVANCE:   state_n = (addr == LAST_ADDR) ? DONE : READ_WAIT;
                DONE:      state_n = IDLE;
                default:   state_n = IDLE;
            endcase
        end
    end

    // Abort freezes the datapath so counters keep their partial values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr         <= '0;
            out_value    <= '0;
            out_count    <= '0;
            out_slot     <= '0;
            entry_count  <= '0;
            total_occurr <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: if (start) begin
                    addr         <= '0;
                    entry_count  <= '0;
                    total_occurr <= '0;
                end
                SAMPLE: begin
                    out_value <= HashValue;
                    out_count <= OccurrValue;
                    out_slot  <= addr;
                end
                EMIT: if (out_ready) begin
                    entry_count  <= entry_count + 1'b1;
                    total_occurr <= total_occurr + out_count;
                end
                ADVANCE: if (addr != LAST_ADDR) addr <= addr + 1'b1;
                DONE:    addr <= '0;
                default: ;
            endcase
        end
    end

`ifdef CLEAR_ON_READ_EN
    logic accepted;

    // Remembers whether the current slot was handed off, so only emitted slots get cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                           accepted <= 1'b0;
        else if (!abort && state == SAMPLE)                 accepted <= 1'b0;
        else if (!abort && state == EMIT && out_ready)      accepted <= 1'b1;
    end

    assign WrEn = (state == ADVANCE) && accepted;
`else
    assign WrEn = 1'b0;
`endif

    assign NewHashValue   = '0;
    assign NewOccurrValue = '0;
    assign HashOccurrAddr = addr;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign out_valid      = (state == EMIT);
endmodule

// File: tb/tb_hash_table_reader.sv
// Randomized self-checking bench for hash_table_reader against a table-level reference model.
module tb_hash_table_reader;
    localparam int DW = 32, BT = 3, AW = 4, N = 8;

    typedef struct packed {
        logic [DW-1:0] h;
        logic [DW-1:0] o;
        logic [AW-1:0] s;
    } trip_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    logic start, abort, busy, done, we, rdy, vld;
    logic [AW-1:0] addr, slot, ecnt;
    logic [DW-1:0] hv, ov, nh, no, val, cnt, tot;

    logic start1, abort1, busy1, done1, we1, rdy1, vld1;
    logic [AW-1:0] addr1, slot1, ecnt1;
    logic [DW-1:0] hv1, ov1, nh1, no1, val1, cnt1, tot1;

    hash_table_reader #(.DATA_INDEX_WIDTH(DW), .BIT_ON_TAILS(BT), .MIN_OCCURR(1)) dut (
        .clk(clk), .rst(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .HashOccurrAddr(addr), .HashValue(hv), .OccurrValue(ov), .WrEn(we),
        .NewHashValue(nh), .NewOccurrValue(no), .out_valid(vld), .out_ready(rdy),
        .out_value(val), .out_count(cnt), .out_slot(slot), .entry_count(ecnt), .total_occurr(tot));

    hash_table_reader #(.DATA_INDEX_WIDTH(DW), .BIT_ON_TAILS(BT), .MIN_OCCURR(3)) dut1 (
        .clk(clk), .rst(rst_n), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
        .HashOccurrAddr(addr1), .HashValue(hv1), .OccurrValue(ov1), .WrEn(we1),
        .NewHashValue(nh1), .NewOccurrValue(no1), .out_valid(vld1), .out_ready(rdy1),
        .out_value(val1), .out_count(cnt1), .out_slot(slot1), .entry_count(ecnt1), .total_occurr(tot1));

    // Synchronous-read tables, one per DUT; model table eh/eo is the expected content
    logic [DW-1:0] mh[N], mo[N], mh1[N], mo1[N], ldh[N], ldo[N], eh[N], eo[N];
    logic load = 1'b0, load1 = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) begin mh[i] <= ldh[i]; mo[i] <= ldo[i]; end
        end else if (we) begin
            mh[addr[BT-1:0]] <= nh;
            mo[addr[BT-1:0]] <= no;
        end
        hv <= mh[addr[BT-1:0]];
        ov <= mo[addr[BT-1:0]];
    end

    always @(posedge clk) begin
        if (load1) begin
            for (int i = 0; i < N; i++) begin mh1[i] <= ldh[i]; mo1[i] <= ldo[i]; end
        end else if (we1) begin
            mh1[addr1[BT-1:0]] <= nh1;
            mo1[addr1[BT-1:0]] <= no1;
        end
        hv1 <= mh1[addr1[BT-1:0]];
        ov1 <= mo1[addr1[BT-1:0]];
    end

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin eh[i] = $urandom; eo[i] = '0; end
    endtask

    task automatic load_table();
        for (int i = 0; i < N; i++) begin ldh[i] = eh[i]; ldo[i] = eo[i]; end
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    // mode 0: always ready; 1: random ready and stray start pulses; 2: first triple stalled 10 cycles
    task automatic scan(input int mode, input string tag);
        trip_t q[$];
        trip_t emitted[$];
        int exp_ent, cyc, stalls, got, wp, hold;
        logic [DW-1:0] exp_tot;
        logic [AW-1:0] last_acc;
        bit fin;
        exp_tot = '0; cyc = 0; stalls = 0; got = 0; wp = 0; hold = 0; fin = 0; last_acc = '0;
        for (int i = 0; i < N; i++)
            if (eo[i] >= 1) begin
                q.push_back('{eh[i], eo[i], AW'(i)});
                exp_tot += eo[i];
            end
        exp_ent = q.size();
        rdy = 1'b1;
        start = 1'b1;
        while (!fin && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = (mode == 1 && $urandom_range(0, 5) == 0);
            if (cyc == 1) begin
                total++;
                if (ecnt !== '0 || tot !== '0) begin
                    bad++; $display("FAIL %s counters_clear: got ecnt=%0d tot=%0d exp 0", tag, ecnt, tot);
                end
            end
            total++;
            if (addr[BT] !== 1'b0) begin
                bad++; $display("FAIL %s addr_range: got %0d", tag, addr);
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
            else begin
                rdy = !(vld && got == 0 && hold < 10);
                if (!rdy) hold++;
            end
            if (vld) begin
                total++;
                if (addr !== slot) begin
                    bad++; $display("FAIL %s addr_hold: got addr=%0d exp %0d", tag, addr, slot);
                end
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL %s extra_triple: got slot=%0d exp none", tag, slot);
                end else if ({val, cnt, slot} !== q[0]) begin
                    bad++; $display("FAIL %s triple: got (%h,%0d,%0d) exp (%h,%0d,%0d)",
                                    tag, val, cnt, slot, q[0].h, q[0].o, q[0].s);
                end
                if (rdy) begin
                    if (q.size() != 0) emitted.push_back(q.pop_front());
                    got++; last_acc = slot;
                end else stalls++;
            end
            if (we) begin
                wp++; total++;
                if (addr !== last_acc || nh !== '0 || no !== '0) begin
                    bad++; $display("FAIL %s wren: got addr=%0d data=%h/%h exp addr=%0d data 0", tag, addr, nh, no, last_acc);
                end
            end
            if (done) fin = 1;
        end
        start = 1'b0;
        total++;
        if (!fin) begin
            bad++; $display("FAIL %s timeout: got no done after %0d cycles", tag, cyc);
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL %s missing: got %0d triples exp %0d", tag, got, exp_ent);
        end
        total++;
        if (cyc != 3 * N + 1 + got + stalls) begin
            bad++; $display("FAIL %s latency: got %0d exp %0d", tag, cyc, 3 * N + 1 + got + stalls);
        end
        total++;
        if (ecnt !== AW'(exp_ent) || tot !== exp_tot) begin
            bad++; $display("FAIL %s totals: got ecnt=%0d tot=%0d exp %0d %0d", tag, ecnt, tot, exp_ent, exp_tot);
        end
`ifdef CLEAR_ON_READ_EN
        total++;
        if (wp != got) begin bad++; $display("FAIL %s wren_count: got %0d exp %0d", tag, wp, got); end
        foreach (emitted[k]) begin eh[emitted[k].s] = '0; eo[emitted[k].s] = '0; end
`else
        total++;
        if (wp != 0) begin bad++; $display("FAIL %s wren_count: got %0d exp 0", tag, wp); end
`endif
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || ecnt !== AW'(exp_ent)) begin
            bad++; $display("FAIL %s after_done: got done=%b busy=%b ecnt=%0d exp 0 0 %0d", tag, done, busy, ecnt, exp_ent);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (mo[i] !== eo[i] || (eo[i] == '0 && mh[i] !== eh[i] && mh[i] !== '0)) begin
                bad++; $display("FAIL %s table[%0d]: got %h/%0d exp %h/%0d", tag, i, mh[i], mo[i], eh[i], eo[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; rdy = 1; start1 = 0; abort1 = 0; rdy1 = 1;
        #12;
        total++;
        if ({busy, done, vld, we, addr, slot, ecnt, val, cnt, tot} !== '0 ||
            {busy1, done1, vld1, we1, addr1, ecnt1, tot1} !== '0) begin
            bad++; $display("FAIL reset: got busy=%b vld=%b addr=%0d ecnt=%0d tot=%0d exp all 0", busy, vld, addr, ecnt, tot);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic two_slot_model();
        clear_model();
        eh[2] = 32'hAB; eo[2] = 5;
        eh[7] = 32'h10; eo[7] = 1;
    endtask

    task automatic test_empty();
        clear_model(); load_table(); scan(0, "empty");
    endtask

    task automatic test_stall();
        two_slot_model(); load_table(); scan(2, "stall");
    endtask

    task automatic test_two_slots();
        two_slot_model(); load_table();
        scan(0, "two_slots");
        total++;
        if (tot !== 32'd6) begin bad++; $display("FAIL two_slots_total: got %0d exp 6", tot); end
        scan(0, "rescan");
    endtask

    task automatic test_abort();
        int n;
        two_slot_model(); load_table();
        rdy = 1'b0; start = 1'b1; n = 0;
        while (!vld && n < 100) begin @(negedge clk); start = 1'b0; n++; end
        total++;
        if (vld !== 1'b1 || slot !== 4'd2) begin
            bad++; $display("FAIL abort_reach_emit: got vld=%b slot=%0d exp 1 2", vld, slot);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        total++;
        if (vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || ecnt !== '0) begin
            bad++; $display("FAIL abort: got vld=%b busy=%b done=%b we=%b ecnt=%0d exp 0", vld, busy, done, we, ecnt);
        end
        n = 0;
        repeat (4) begin @(negedge clk); if (done || busy) n++; end
        total++;
        if (n != 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles exp 0", n); end
        scan(0, "after_abort");
    endtask

    task automatic test_start_abort();
        start = 1'b1; abort = 1'b1;
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_abort: got busy=%b exp 0", busy); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL start_abort_hold: got busy=%b exp 0", busy); end
    endtask

    task automatic test_min_occurr();
        int n, hits;
        logic [DW-1:0] v1, v4;
        v1 = $urandom; v4 = $urandom;
        for (int i = 0; i < N; i++) begin ldh[i] = '0; ldo[i] = '0; end
        ldh[1] = v1; ldo[1] = 2;
        ldh[4] = v4; ldo[4] = 3;
        @(negedge clk) load1 = 1'b1;
        @(negedge clk) load1 = 1'b0;
        rdy1 = 1'b1; start1 = 1'b1; n = 0; hits = 0;
        while (!done1 && n < 200) begin
            @(negedge clk); start1 = 1'b0; n++;
            if (vld1) begin
                hits++; total++;
                if ({val1, cnt1, slot1} !== {v4, 32'd3, 4'd4}) begin
                    bad++; $display("FAIL min_occurr_triple: got (%h,%0d,%0d) exp (%h,3,4)", val1, cnt1, slot1, v4);
                end
            end
        end
        total++;
        if (hits != 1 || n != 3 * N + 2 || ecnt1 !== 4'd1 || tot1 !== 32'd3) begin
            bad++; $display("FAIL min_occurr: got hits=%0d cyc=%0d ecnt=%0d tot=%0d exp 1 %0d 1 3", hits, n, ecnt1, tot1, 3 * N + 2);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                eh[i] = $urandom;
                case ($urandom_range(0, 3))
                    0, 1:    eo[i] = '0;
                    2:       eo[i] = $urandom_range(1, 1000);
                    default: eo[i] = $urandom | 32'h8000_0000;
                endcase
            end
            load_table();
            scan(1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_stall();
        test_two_slots();
        test_abort();
        test_start_abort();
        test_min_occurr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
